// File: rtl/fb_pkg.sv
// Frame-buffer shared definitions: default geometry, pixel and address
// types, and the port-B arbiter state encoding.
package fb_pkg;
  localparam int FB_DEPTH    = 320*240;
  localparam int FB_ADDR_W   = 17;
  localparam int COLOR_DEPTH = 12;

  typedef logic [FB_ADDR_W-1:0]   fb_addr_t;
  typedef logic [COLOR_DEPTH-1:0] fb_pixel_t;

  typedef enum logic {IDLE, CLEAR} arb_state_t;
endpackage

// File: rtl/fb_write_arbiter_clear_sequencer.sv
// clear_sequencer: walks a pointer 0..DEPTH-1 across the frame buffer.
// Ports:
//   clk_in, rst_in : pixel clock, async active-low reset
//   start          : request a sweep (ignored while a sweep is active)
//   advance        : arbiter granted the current ptr a clear write this cycle
//   ptr            : address of the next clear write
//   busy           : sweep pending or in progress (registered state)
//   done           : one-cycle pulse aligned with the final clear write output
module clear_sequencer
  import fb_pkg::*;
#(
  parameter int DEPTH  = FB_DEPTH,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              done_nxt;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
      CLEAR: if (advance) begin
        // Terminal compare is against the real depth, so ptr never wraps.
        if (ptr == LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      done  <= done_nxt;
    end
  end

  // State is a register, so busy drops in the same cycle done rises.
  assign busy = (state == CLEAR);
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: owns BRAM port B of the IIR/VSG frame buffers.
// The trail_iir stream always wins; the clear sweep fills idle cycles.
// Optional macro FB_ARB_AUTOCLEAR_EN: start a sweep every AUTO_FRAMES
// frame_done pulses (skipped if a sweep is already running).
// Ports:
//   clk_in, rst_in                        : pixel clock, async active-low reset
//   strm_valid_in/addr_in/data_in         : IIR update write
//   clear_start_in                        : one-cycle clear request
//   frame_done_in                         : end-of-frame pulse (autoclear only)
//   web_out, addrb_out, dinb_out          : registered port-B write
//   clear_busy_out, clear_done_out        : sweep status
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int                DEPTH       = FB_DEPTH,
  parameter int                ADDR_W      = FB_ADDR_W,
  parameter int                DATA_W      = COLOR_DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
  parameter int                AUTO_FRAMES = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              strm_valid_in,
  input  logic [ADDR_W-1:0] strm_addr_in,
  input  logic [DATA_W-1:0] strm_data_in,
  input  logic              clear_start_in,
  input  logic              frame_done_in,
  output logic              web_out,
  output logic [ADDR_W-1:0] addrb_out,
  output logic [DATA_W-1:0] dinb_out,
  output logic              clear_busy_out,
  output logic              clear_done_out
);
  logic              busy, done, start, advance, auto_start;
  logic [ADDR_W-1:0] ptr;

  // Sweep only takes cycles the stream leaves free.
  assign advance = busy & ~strm_valid_in;
  assign start   = clear_start_in | auto_start;

`ifdef FB_ARB_AUTOCLEAR_EN
  localparam int CNT_W = ($clog2(AUTO_FRAMES) > 6) ? $clog2(AUTO_FRAMES) : 6;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_hit;

  assign frame_hit  = frame_done_in && (frame_cnt == CNT_W'(AUTO_FRAMES-1));
  // Counter restarts on the hit even when busy; that auto start is dropped.
  assign auto_start = frame_hit & ~busy;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)            frame_cnt <= '0;
    else if (frame_hit)     frame_cnt <= '0;
    else if (frame_done_in) frame_cnt <= frame_cnt + 1'b1;
  end
`else
  localparam int unused_auto_frames = AUTO_FRAMES;
  logic unused_frame_done;
  assign unused_frame_done = frame_done_in;
  assign auto_start        = 1'b0;
`endif

  clear_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start   (start),
    .advance (advance),
    .ptr     (ptr),
    .busy    (busy),
    .done    (done)
  );

  // Address/data hold on idle cycles to avoid needless BRAM input toggling.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      web_out   <= 1'b0;
      addrb_out <= '0;
      dinb_out  <= '0;
    end else if (strm_valid_in) begin
      web_out   <= 1'b1;
      addrb_out <= strm_addr_in;
      dinb_out  <= strm_data_in;
    end else if (advance) begin
      web_out   <= 1'b1;
      addrb_out <= ptr;
      dinb_out  <= CLEAR_VALUE;
    end else begin
      web_out   <= 1'b0;
    end
  end

  assign clear_busy_out = busy;
  assign clear_done_out = done;
endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strm_valid = 1'b0;
  logic [4:0]  strm_addr = '0;
  logic [11:0] strm_data = '0;
  logic        clear_start = 1'b0;
  logic        frame_done = 1'b0;
  logic        web, busy, done;
  logic [4:0]  addrb;
  logic [11:0] dinb;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .DEPTH(16), .ADDR_W(5), .DATA_W(12), .CLEAR_VALUE(12'h000), .AUTO_FRAMES(4)
  ) dut (
    .clk_in(clk), .rst_in(rst_n),
    .strm_valid_in(strm_valid), .strm_addr_in(strm_addr), .strm_data_in(strm_data),
    .clear_start_in(clear_start), .frame_done_in(frame_done),
    .web_out(web), .addrb_out(addrb), .dinb_out(dinb),
    .clear_busy_out(busy), .clear_done_out(done)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [11:0] data;
    logic        done;
  } wr_t;

  wr_t         q[$];
  logic [11:0] mem[16];
  logic [11:0] expmem[16];
  int          n_cmp = 0, n_bad = 0;
  int          ndone = 0, nwr = 0;
  bit          mbusy = 0;
  int          mptr = 0, mfcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every port-B write.
  always @(negedge clk) if (rst_n) begin
    if (web) begin
      nwr++;
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", addrb, dinb);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(addrb), 32'(e.addr));
        chk("wr_data", 32'(dinb), 32'(e.data));
        chk("wr_done", 32'(done), 32'(e.done));
        if (e.done) chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (addrb < 16) mem[addrb] = dinb;
      if (done) ndone++;
    end else if (done) begin
      ndone++;
      n_cmp++; n_bad++;
      $display("FAIL done_without_write: got done=1 with web=0, expected done only with last clear write");
    end
  end

  // One cycle of stimulus; the reference model pushes the expected write.
  task automatic cyc(input bit v, input logic [4:0] a, input logic [11:0] d,
                     input bit st, input bit fd);
    bit  b0, go;
    wr_t e;
    strm_valid = v; strm_addr = a; strm_data = d;
    clear_start = st; frame_done = fd;
    b0 = mbusy;
    go = st;
    if (v) begin
      e.addr = a; e.data = d; e.done = 1'b0;
      q.push_back(e);
      expmem[a] = d;
    end else if (mbusy) begin
      e.addr = 5'(mptr); e.data = 12'h000; e.done = (mptr == 15);
      q.push_back(e);
      expmem[mptr] = 12'h000;
      if (mptr == 15) mbusy = 0;
      else mptr++;
    end
`ifdef FB_ARB_AUTOCLEAR_EN
    if (fd) begin
      if (mfcnt == 3) begin
        mfcnt = 0;
        if (!b0) go = 1;
      end else mfcnt++;
    end
`endif
    if (go && !b0) begin
      mbusy = 1;
      mptr = 0;
    end
    @(posedge clk); #1;
    chk("busy", 32'(busy), 32'(mbusy));
    strm_valid = 0; clear_start = 0; frame_done = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 12'h000, 0, 0);
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== expmem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, k;
    for (int i = 0; i < 16; i++) begin mem[i] = 12'h000; expmem[i] = 12'h000; end

    // 1: reset holds outputs at 0 even with a stream request present
    strm_valid = 1; strm_addr = 5'd3; strm_data = 12'hABC;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_web", 32'(web), 0);
    chk("rst_addrb", 32'(addrb), 0);
    chk("rst_dinb", 32'(dinb), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1;
    cyc(1, 5'd3, 12'hABC, 0, 0);
    idle(2);

    // 2: plain sweep, 16 writes addr 0..15
    d0 = ndone; w0 = nwr;
    cyc(0, 5'd0, 12'h000, 1, 0);
    idle(20);
    chk("t2_done_pulses", 32'(ndone - d0), 1);
    chk("t2_writes", 32'(nwr - w0), 16);
    chk_mem("t2_mem");

    // 3: sweep with stream on alternate cycles
    d0 = ndone;
    cyc(0, 5'd0, 12'h000, 1, 0);
    for (int i = 0; i < 40; i++) cyc(i % 2 == 0, 5'd9, 12'hF0F, 0, 0);
    idle(2);
    chk("t3_busy_end", 32'(busy), 0);
    chk("t3_done_pulses", 32'(ndone - d0), 1);
    chk("t3_mem9_survives", 32'(mem[9]), 32'h0F0F);
    chk_mem("t3_mem");

    // 4: clear_start while busy at ptr=7 is ignored
    d0 = ndone; w0 = nwr;
    cyc(0, 5'd0, 12'h000, 1, 0);
    k = 0;
    while (mptr != 7 && k < 20) begin idle(1); k++; end
    cyc(0, 5'd0, 12'h000, 1, 0);
    idle(20);
    chk("t4_done_pulses", 32'(ndone - d0), 1);
    chk("t4_writes", 32'(nwr - w0), 16);

    // 5: async reset mid-sweep at ptr=5
    d0 = ndone;
    cyc(0, 5'd0, 12'h000, 1, 0);
    k = 0;
    while (mptr != 5 && k < 20) begin idle(1); k++; end
    #6;
    rst_n = 0;
    #1;
    chk("t5_rst_web", 32'(web), 0);
    chk("t5_rst_addrb", 32'(addrb), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_queue_drained", 32'(q.size()), 0);
    chk("t5_no_done", 32'(ndone - d0), 0);
    mbusy = 0; mptr = 0; mfcnt = 0;
    #1 rst_n = 1;
    d0 = ndone; w0 = nwr;
    cyc(0, 5'd0, 12'h000, 1, 0);
    idle(20);
    chk("t5_restart_done", 32'(ndone - d0), 1);
    chk("t5_restart_writes", 32'(nwr - w0), 16);

    // 6: frame_done pulses (autoclear every 4 when enabled)
    d0 = ndone;
    for (int i = 0; i < 4; i++) begin cyc(0, 5'd0, 12'h000, 0, 1); idle(2); end
    idle(20);
    for (int i = 0; i < 3; i++) begin cyc(0, 5'd0, 12'h000, 0, 1); idle(2); end
    cyc(0, 5'd0, 12'h000, 1, 0);
    cyc(0, 5'd0, 12'h000, 0, 1);
    idle(25);
`ifdef FB_ARB_AUTOCLEAR_EN
    chk("t6_done_pulses", 32'(ndone - d0), 2);
`else
    chk("t6_done_pulses", 32'(ndone - d0), 1);
`endif
    chk("t6_busy_end", 32'(busy), 0);

    chk("final_queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
